// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Time-multiplexed scanner for a COUNT-digit seven-segment display.
//   - A free-running prescaler divides the clock into digit slots of
//     DIVIDE clocks each.
//   - The scan index steps through the digits once per slot.
//   - Each slot opens with GUARD dead-time clocks, during which every
//     digit is off, so that segment ghosting between digits is avoided.
//   - New data is staged in a pending register. It reaches the visible
//     display only at a frame boundary, so a frame never shows a mix of
//     old and new digits.
//
// Parameters
//   COUNT       : number of digits (2..8)
//   DIVIDE      : clocks per digit slot (4..65535)
//   GUARD       : dead-time clocks at the start of each slot (0..DIVIDE-2)
//   ACTIVE      : digit_en polarity (1 = active high, 0 = active low)
//   BLANK_ZEROS : 1 suppresses leading zeros
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   load       in   capture value/dp into the pending register
//   value      in   COUNT hex nibbles; nibble i = value[4i+3:4i], top = MSD
//   dp         in   decimal point per digit
//   digit_hex  out  nibble of the digit being scanned
//   dp_out     out  decimal point of the digit being scanned
//   digit_en   out  one-hot (in ACTIVE polarity) digit select
//   frame_done out  one-cycle pulse after the index wraps to digit 0
//   pending    out  loaded data waiting for the next frame boundary
module seg_display_scanner #(
  parameter int COUNT       = 4,
  parameter int DIVIDE      = 1000,
  parameter int GUARD       = 2,
  parameter int ACTIVE      = 1,
  parameter int BLANK_ZEROS = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT*4-1:0] value,
  input  logic [COUNT-1:0]   dp,
  output logic [3:0]         digit_hex,
  output logic               dp_out,
  output logic [COUNT-1:0]   digit_en,
  output logic               frame_done,
  output logic               pending
);

  localparam int PW = $clog2(DIVIDE);
  localparam int IW = $clog2(COUNT);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIVIDE - 1);
  localparam logic [PW-1:0] PRE_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(COUNT - 1);
  localparam logic          ON_LVL    = (ACTIVE != 0);

  logic [PW-1:0]      prescaler;
  logic [IW-1:0]      index;
  logic               tick;
  logic               wrap;
  logic [COUNT*4-1:0] pend_value;
  logic [COUNT-1:0]   pend_dp;
  logic [COUNT*4-1:0] disp_value;
  logic [COUNT-1:0]   disp_dp;
  logic [COUNT-1:0]   blank;
  logic               upper_nonzero;

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (index == IDX_LAST);

  // ---- scan timing: prescaler and digit index ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      index     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= wrap ? '0 : index + IW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // ---- frame boundary: pending -> display handoff ----
  // When a load coincides with the wrap tick, the old pending data moves
  // to the display, and the new data lands in pending. Both happen in the
  // same edge, because the display reads the pre-edge pending contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
      pending    <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      disp_value <= '0;
      disp_dp    <= '0;
    end else begin
      frame_done <= wrap;
      if (wrap && pending) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending    <= 1'b0;
      end
    end
  end

  // ---- output select and leading-zero blanking ----
  assign digit_hex = disp_value[{index, 2'b00} +: 4];
  assign dp_out    = disp_dp[index];

  // Walk from the most significant digit downward. A digit is blanked
  // while everything at or above it is still zero with no decimal point.
  always_comb begin
    upper_nonzero = 1'b0;
    blank         = '0;
    for (int k = COUNT - 1; k >= 0; k--) begin
      upper_nonzero = upper_nonzero | (disp_value[4*k +: 4] != 4'h0) | disp_dp[k];
      blank[k]      = (BLANK_ZEROS != 0) && (k != 0) && !upper_nonzero;
    end
  end

  always_comb begin
    digit_en = {COUNT{~ON_LVL}};
    for (int k = 0; k < COUNT; k++) begin
      if ((index == IW'(k)) && (prescaler >= PRE_GUARD) && !blank[k])
        digit_en[k] = ON_LVL;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  en_mask;
    logic        pend;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;
  logic [3:0]  digit_hex;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        pending;

  logic        bz_load  = 1'b0;
  logic [15:0] bz_value = '0;
  logic [3:0]  bz_dp    = '0;
  logic [3:0]  bz_digit_hex;
  logic        bz_dp_out;
  logic [3:0]  bz_digit_en;
  logic        bz_frame_done;
  logic        bz_pending;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  exp_t q_main[$];
  exp_t q_bz[$];

  always #5 clock = ~clock;

  seg_display_scanner #(.COUNT(4), .DIVIDE(8), .GUARD(2), .ACTIVE(1), .BLANK_ZEROS(0)) u_dut (
    .clock(clock), .reset(reset), .load(load), .value(value), .dp(dp),
    .digit_hex(digit_hex), .dp_out(dp_out), .digit_en(digit_en),
    .frame_done(frame_done), .pending(pending)
  );

  seg_display_scanner #(.COUNT(4), .DIVIDE(8), .GUARD(2), .ACTIVE(1), .BLANK_ZEROS(1)) u_bz (
    .clock(clock), .reset(reset), .load(bz_load), .value(bz_value), .dp(bz_dp),
    .digit_hex(bz_digit_hex), .dp_out(bz_dp_out), .digit_en(bz_digit_en),
    .frame_done(bz_frame_done), .pending(bz_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 64; i++) begin
      if (frame_done) break;
      step(1);
    end
    chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Entered in the first cycle of a frame; samples each slot after the guard.
  task automatic check_frame(input bit bz);
    exp_t e;
    logic [3:0] obs_hex, obs_en;
    logic       obs_dp, obs_pend;
    if (bz) begin
      chk("sb_bz_nonempty", {31'd0, q_bz.size() != 0}, 32'd1);
      e = (q_bz.size() != 0) ? q_bz.pop_front() : '0;
    end else begin
      chk("sb_nonempty", {31'd0, q_main.size() != 0}, 32'd1);
      e = (q_main.size() != 0) ? q_main.pop_front() : '0;
    end
    for (int d = 0; d < 4; d++) begin
      step(d == 0 ? 2 : 8);
      obs_hex  = bz ? bz_digit_hex : digit_hex;
      obs_en   = bz ? bz_digit_en  : digit_en;
      obs_dp   = bz ? bz_dp_out    : dp_out;
      obs_pend = bz ? bz_pending   : pending;
      chk($sformatf("hex_d%0d", d), {28'd0, obs_hex}, {28'd0, e.val[4*d +: 4]});
      chk($sformatf("dp_d%0d", d), {31'd0, obs_dp}, {31'd0, e.dpv[d]});
      chk($sformatf("en_d%0d", d), {28'd0, obs_en}, e.en_mask[d] ? (32'd1 << d) : 32'd0);
      chk($sformatf("pend_d%0d", d), {31'd0, obs_pend}, {31'd0, e.pend});
      if (d == 0) chk("frame_done_low", {31'd0, frame_done}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    step(3);
    chk("rst_en", {28'd0, digit_en}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_hex", {28'd0, digit_hex}, 32'd0);
    reset = 1'b0;
    cyc = 0;

    // ---- free-running scan with no load ----
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("scan_en_c%0d", c), {28'd0, digit_en},
          ((c % 8) >= 2) ? (32'd1 << ((c / 8) % 4)) : 32'd0);
      chk($sformatf("scan_fd_c%0d", c), {31'd0, frame_done}, (c == 32) ? 32'd1 : 32'd0);
      chk($sformatf("scan_hex_c%0d", c), {28'd0, digit_hex}, 32'd0);
      step(1);
    end

    // ---- single load mid-frame ----
    load = 1'b1; value = 16'h1234; dp = 4'b0101;
    q_main.push_back('{val: 16'h1234, dpv: 4'b0101, en_mask: 4'hF, pend: 1'b0});
    step(1);
    load = 1'b0;
    chk("ld1_pending", {31'd0, pending}, 32'd1);
    chk("ld1_hex_unchanged", {28'd0, digit_hex}, 32'd0);
    wait_frame();
    check_frame(1'b0);

    // ---- overwrite within one frame ----
    load = 1'b1; value = 16'hAAAA; dp = 4'b1111;
    step(1);
    value = 16'h5555; dp = 4'b0010;
    q_main.push_back('{val: 16'h5555, dpv: 4'b0010, en_mask: 4'hF, pend: 1'b0});
    step(1);
    load = 1'b0;
    chk("ovw_pending", {31'd0, pending}, 32'd1);
    chk("ovw_hex_old", {28'd0, digit_hex}, 32'd1);
    wait_frame();
    check_frame(1'b0);

    // ---- load exactly on the wrap tick ----
    load = 1'b1; value = 16'h1111; dp = 4'b0000;
    q_main.push_back('{val: 16'h1111, dpv: 4'b0000, en_mask: 4'hF, pend: 1'b1});
    step(1);
    load = 1'b0;
    step(4);
    load = 1'b1; value = 16'hBEEF; dp = 4'b1000;
    q_main.push_back('{val: 16'hBEEF, dpv: 4'b1000, en_mask: 4'hF, pend: 1'b0});
    step(1);
    load = 1'b0;
    chk("wraptick_fd", {31'd0, frame_done}, 32'd1);
    wait_frame();
    check_frame(1'b0);
    wait_frame();
    check_frame(1'b0);

    // ---- asynchronous reset with a load pending ----
    load = 1'b1; value = 16'h7777; dp = 4'b1111;
    step(1);
    load = 1'b0;
    chk("pre_rst_pending", {31'd0, pending}, 32'd1);
    chk("pre_rst_hex", {28'd0, digit_hex}, 32'hB);
    reset = 1'b1;
    #1;
    chk("arst_en", {28'd0, digit_en}, 32'd0);
    chk("arst_pending", {31'd0, pending}, 32'd0);
    chk("arst_hex", {28'd0, digit_hex}, 32'd0);
    chk("arst_dp", {31'd0, dp_out}, 32'd0);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
    chk("post_c0_en", {28'd0, digit_en}, 32'd0);
    step(7);
    chk("post_c7_en", {28'd0, digit_en}, 32'd1);
    step(1);
    chk("post_c8_en", {28'd0, digit_en}, 32'd0);
    step(2);
    chk("post_c10_en", {28'd0, digit_en}, 32'd2);
    chk("post_pending", {31'd0, pending}, 32'd0);
    q_main.push_back('{val: 16'h0000, dpv: 4'b0000, en_mask: 4'hF, pend: 1'b0});
    wait_frame();
    chk("post_first_wrap_cyc", cyc, 32'd32);
    check_frame(1'b0);

    // ---- leading-zero suppression ----
    bz_load = 1'b1; bz_value = 16'h0040; bz_dp = 4'b0000;
    q_bz.push_back('{val: 16'h0040, dpv: 4'b0000, en_mask: 4'b0011, pend: 1'b0});
    step(1);
    bz_load = 1'b0;
    wait_frame();
    check_frame(1'b1);
    bz_load = 1'b1; bz_value = 16'h0040; bz_dp = 4'b1000;
    q_bz.push_back('{val: 16'h0040, dpv: 4'b1000, en_mask: 4'b1111, pend: 1'b0});
    step(1);
    bz_load = 1'b0;
    wait_frame();
    check_frame(1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
